aes128_key_sched: RTL and testbench

- Iterative AES-128 key-expansion sequencer. Sits directly downstream of GFunction, whose gVal output it consumes, and directly upstream of the encryption round datapath.
- Latches a 128-bit cipher key, then emits round keys 0..LAST_ROUND, one per accepted valid/ready transfer.
- Computes each next round key in one cycle from the current one, using a single GFunction instance.

---
 rtl/aes_pkg.sv | 58 +++++
 rtl/GFunction.sv | 21 ++
 rtl/aes128_key_step.sv | 29 ++
 rtl/aes128_key_sched.sv | 114 +++++++++++
 tb/tb_aes128_key_sched.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared constants, state encoding and byte-level helpers for the AES-128 key schedule.
package aes_pkg;

    localparam int AES_NR = 10;
    localparam int RK_W   = 128;
    localparam int WORD_W = 32;
    localparam int RIDX_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EMIT   = 2'd1,
        FINISH = 2'd2
    } ks_state_e;

    // Forward AES S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb8145ede0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry b sits at bit offset (255-b)*8, and 255-b is simply ~b.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/GFunction.sv
// Key-schedule g() on one word: RotWord, SubWord, then XOR of the round constant into the top byte.
module GFunction
    import aes_pkg::*;
(
    input  logic [WORD_W-1:0] val,
    input  logic [WORD_W-1:0] round,
    output logic [WORD_W-1:0] gVal
);

    logic [WORD_W-1:0] rot;
    logic [WORD_W-1:0] sub;
    logic [7:0]        rc;

    assign rot = {val[23:0], val[31:24]};
    assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};

    // Rounds outside 1..10 (including any high bits set) get no round constant.
    assign rc   = (round[WORD_W-1:4] == '0) ? rcon(round[3:0]) : 8'h00;
    assign gVal = sub ^ {rc, 24'h000000};

endmodule

// File: rtl/aes128_key_step.sv
// One step of AES-128 key expansion: next round key from the current one and its target round number.
module aes128_key_step
    import aes_pkg::*;
(
    input  logic [RK_W-1:0]   key_i,
    input  logic [RIDX_W-1:0] round_i,
    output logic [RK_W-1:0]   next_key_o
);

    logic [WORD_W-1:0] w0, w1, w2, w3;
    logic [WORD_W-1:0] t;
    logic [WORD_W-1:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = key_i;

    GFunction u_gfunc (
        .val   (w3),
        .round ({{(WORD_W-RIDX_W){1'b0}}, round_i}),
        .gVal  (t)
    );

    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign next_key_o = {n0, n1, n2, n3};

endmodule

// File: rtl/aes128_key_sched.sv
// Iterative AES-128 key-expansion sequencer: latches a key and hands out round keys 0..LAST_ROUND
// over a valid/ready interface, computing each following key in a single cycle.
//
// state  | meaning
// IDLE   | waiting for start; outputs at reset values
// EMIT   | round_key/round_idx valid, advance on each accepted transfer
// FINISH | one-cycle done pulse after the final transfer, key cleared if ZEROIZE
module aes128_key_sched
    import aes_pkg::*;
#(
    parameter int LAST_ROUND = 10,
    parameter bit ZEROIZE    = 1'b1
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [RK_W-1:0]   key_in,
    input  logic              rk_ready,
    output logic              rk_valid,
    output logic [RK_W-1:0]   round_key,
    output logic [RIDX_W-1:0] round_idx,
    output logic              busy,
    output logic              done
);

    localparam logic [RIDX_W-1:0] LAST_IDX = RIDX_W'(LAST_ROUND);

    ks_state_e         state_q, state_d;
    // The current round key doubles as the key register: round 0 is the cipher key itself.
    logic [RK_W-1:0]   rk_q, rk_d;
    logic [RIDX_W-1:0] idx_q, idx_d;
    logic              valid_q, valid_d;

    logic [RK_W-1:0]   next_rk;
    logic [RIDX_W-1:0] idx_inc;
    logic              xfer;

    assign idx_inc = idx_q + 4'd1;
    assign xfer    = valid_q & rk_ready;

    aes128_key_step u_step (
        .key_i      (rk_q),
        .round_i    (idx_inc),
        .next_key_o (next_rk)
    );

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rk_q    <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    // Next-state, key advance and handshake; everything holds unless a transition fires.
    always_comb begin
        state_d = state_q;
        rk_d    = rk_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rk_d    = key_in;
                    idx_d   = '0;
                    valid_d = 1'b1;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
                        valid_d = 1'b0;
                        state_d = FINISH;
                        if (ZEROIZE) begin
                            rk_d = '0;
                        end
                    end else begin
                        rk_d  = next_rk;
                        idx_d = idx_inc;
                    end
                end
            end
            FINISH: begin
                // IDLE always presents reset values, so nothing of the key survives past here.
                rk_d    = '0;
                idx_d   = '0;
                valid_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                rk_d    = '0;
                idx_d   = '0;
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign rk_valid  = valid_q;
    assign round_key = rk_q;
    assign round_idx = idx_q;
    assign busy      = (state_q == EMIT);
    assign done      = (state_q == FINISH);

endmodule

// File: tb/tb_aes128_key_sched.sv
// Bench for aes128_key_sched: FIPS-197 vectors, random keys with backpressure, start-while-busy,
// mid-run reset, and a LAST_ROUND=3 instance. Reference key expansion built from GF(2^8) arithmetic.
module tb_aes128_key_sched;

    localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A1_RK1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A1_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10= 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] KEY_B    = 128'h000102030405060708090a0b0c0d0e0f;

    logic         clk = 1'b0;
    logic         rst_n, start, rk_ready;
    logic [127:0] key_in;
    logic         rk_valid, busy, done;
    logic [127:0] round_key;
    logic [3:0]   round_idx;

    logic         s_start, s_rk_ready;
    logic [127:0] s_key_in;
    logic         s_rk_valid, s_busy, s_done;
    logic [127:0] s_round_key;
    logic [3:0]   s_round_idx;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbox_ref [256];
    logic [127:0] exp_rk [11];
    logic [127:0] cap [11];

    always #5 clk = ~clk;

    aes128_key_sched dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .rk_ready(rk_ready),
        .rk_valid(rk_valid), .round_key(round_key), .round_idx(round_idx), .busy(busy), .done(done)
    );

    aes128_key_sched #(.LAST_ROUND(3), .ZEROIZE(1'b1)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .key_in(s_key_in), .rk_ready(s_rk_ready),
        .rk_valid(s_rk_valid), .round_key(s_round_key), .round_idx(s_round_idx), .busy(s_busy), .done(s_done)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
    task automatic build_sbox;
        logic [7:0] inv, r1, r2, r3, r4;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            r1 = {inv[6:0], inv[7]};
            r2 = {r1[6:0], r1[7]};
            r3 = {r2[6:0], r2[7]};
            r4 = {r3[6:0], r3[7]};
            sbox_ref[x] = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
        end
    endtask

    // Word-wise FIPS-197 key expansion into exp_rk[0..10].
    task automatic compute_ref(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]};
                t = t ^ {rc, 24'h000000};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Full run on the LAST_ROUND=10 instance. pct = rk_ready probability in percent.
    // inj_idx >= 0 raises start with inj_key while that index is presented and again in the done cycle.
    task automatic run_main(input logic [127:0] key, input int pct, input int inj_idx, input logic [127:0] inj_key);
        int          exp_idx, transfers, dones, done_edge;
        logic        hold, fin;
        logic [127:0] h_key;
        logic [3:0]  h_idx;
        compute_ref(key);
        key_in = key;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        key_in = {$urandom, $urandom, $urandom, $urandom};
        exp_idx = 0; transfers = 0; dones = 0; done_edge = 0;
        hold = 1'b0; fin = 1'b0; h_key = '0; h_idx = '0;
        for (int c = 0; c < 400 && !fin; c++) begin
            if (hold) begin
                check("bp_key_stable", round_key, h_key);
                check("bp_idx_stable", round_idx, h_idx);
                check("bp_valid_held", rk_valid, 1);
            end
            if (rk_valid && exp_idx > 10) begin
                check("idx_overrun", exp_idx, 10);
                fin = 1'b1;
            end else if (rk_valid) begin
                check("round_idx", round_idx, exp_idx);
                check("round_key", round_key, exp_rk[exp_idx]);
                check("busy_emit", busy, 1);
                cap[exp_idx] = round_key;
            end
            if (done) begin
                dones++;
                if (dones == 1) done_edge = c + 1;
                check("zeroize_done", round_key, 0);
                check("busy_in_done", busy, 0);
            end
            if (!rk_valid && !done) begin
                fin   = 1'b1;
                start = 1'b0;
            end
            if (!fin) begin
                rk_ready = ($urandom_range(0, 99) < pct);
                start    = (inj_idx >= 0) && ((rk_valid && exp_idx == inj_idx) || done);
                key_in   = start ? inj_key : {$urandom, $urandom, $urandom, $urandom};
                hold     = rk_valid && !rk_ready;
                h_key    = round_key;
                h_idx    = round_idx;
                if (rk_valid && rk_ready) begin
                    transfers++;
                    exp_idx++;
                end
                tick();
            end
        end
        check("run_finished", fin, 1);
        check("transfers", transfers, 11);
        check("done_pulses", dones, 1);
        if (pct == 100) check("done_edge", done_edge, 12);
        check("idle_valid", rk_valid, 0);
        check("idle_key", round_key, 0);
        check("idle_busy", busy, 0);
        start    = 1'b0;
        rk_ready = 1'b0;
    endtask

    task automatic run_small(input logic [127:0] key);
        compute_ref(key);
        s_key_in = key;
        s_start  = 1'b1;
        tick();
        s_start  = 1'b0;
        s_key_in = {$urandom, $urandom, $urandom, $urandom};
        for (int k = 0; k < 4; k++) begin
            check("s_valid", s_rk_valid, 1);
            check("s_idx", s_round_idx, k);
            check("s_key", s_round_key, exp_rk[k]);
            tick();
        end
        check("s_done", s_done, 1);
        check("s_valid_done", s_rk_valid, 0);
        check("s_zeroize_done", s_round_key, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("s_done_low", s_done, 0);
            check("s_idle_key", s_round_key, 0);
            check("s_idle_idx", s_round_idx, 0);
            check("s_idle_valid", s_rk_valid, 0);
        end
    endtask

    task automatic run_reset_mid(input logic [127:0] key, input logic [127:0] key2);
        compute_ref(key);
        key_in   = key;
        start    = 1'b1;
        rk_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 20 && round_idx != 4'd6; c++) tick();
        check("reached_idx6", round_idx, 6);
        check("key_idx6", round_key, exp_rk[6]);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_valid", rk_valid, 0);
        check("rst_key", round_key, 0);
        check("rst_idx", round_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        tick();
        check("rst_idle_valid", rk_valid, 0);
        rk_ready = 1'b0;
        run_main(key2, 100, -1, '0);
    endtask

    initial begin
        build_sbox();
        rst_n = 1'b0; start = 1'b0; rk_ready = 1'b0; key_in = '0;
        s_start = 1'b0; s_rk_ready = 1'b1; s_key_in = '0;
        tick();
        tick();
        check("reset_valid", rk_valid, 0);
        check("reset_key", round_key, 0);
        check("reset_idx", round_idx, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_s_valid", s_rk_valid, 0);
        rst_n = 1'b1;
        rk_ready = 1'b1;
        tick();
        check("idle_no_start", rk_valid, 0);

        run_main(KEY_A1, 100, -1, '0);
        check("a1_idx0", cap[0], KEY_A1);
        check("a1_idx1", cap[1], A1_RK1);
        check("a1_idx10", cap[10], A1_RK10);

        run_main('0, 100, -1, '0);
        check("zero_idx1", cap[1], ZERO_RK1);
        check("zero_idx10", cap[10], ZERO_RK10);

        run_main(KEY_A1, 30, -1, '0);
        check("bp_a1_idx10", cap[10], A1_RK10);

        run_main(KEY_A1, 100, 4, KEY_B);
        check("busy_start_idx10", cap[10], A1_RK10);
        run_main(KEY_B, 100, -1, '0);
        check("new_key_idx0", cap[0], KEY_B);

        run_reset_mid({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});

        for (int n = 0; n < 2; n++) run_main({$urandom, $urandom, $urandom, $urandom}, 50, -1, '0);

        run_small(KEY_A1);
        check("s_a1_idx1_ref", exp_rk[1], A1_RK1);
        run_small({$urandom, $urandom, $urandom, $urandom});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
